fetch_ctrl: RTL and testbench

- Drives the program counter's next-address input (`PC_In`) and its write-enable (`PCWrite`).
- Issues instruction-memory requests over a valid/ready request channel with a separate response-valid return.
- Presents fetched instructions to the IF/ID boundary.
- Handles load-use stalls, taken-branch redirects and response draining. All instruction fetch sequencing lives here; the PC register itself only stores.

---
 rtl/fetch_ctrl.sv | 139 +++++++++++++
 tb/tb_fetch_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: drives PC next-address/write-enable, issues imem
// requests one at a time, and fills the IF/ID boundary registers.
module fetch_ctrl #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32,
    parameter int PC_STEP = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_cur,
    output logic [ADDR_W-1:0]  pc_next,
    output logic               pc_write,
    input  logic               hazard_stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               imem_req_valid,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    output logic               if_valid,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INSTR_W-1:0] if_instr,
    output logic               flush
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_e;

    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(3);

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    req_pc_q, req_pc_d;
    logic [INSTR_W-1:0]   buf_q, buf_d;
    logic                 if_valid_q, if_valid_d;
    logic [ADDR_W-1:0]    if_pc_q, if_pc_d;
    logic [INSTR_W-1:0]   if_instr_q, if_instr_d;
    logic                 redirect;
    logic                 deliver;
    logic [INSTR_W-1:0]   dlv_instr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            req_pc_q   <= '0;
            buf_q      <= '0;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
        end else begin
            state_q    <= state_d;
            req_pc_q   <= req_pc_d;
            buf_q      <= buf_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        req_pc_d       = req_pc_q;
        buf_d          = buf_q;
        deliver        = 1'b0;
        dlv_instr      = buf_q;
        redirect       = branch_taken && (state_q != IDLE);
        pc_next        = pc_cur;
        pc_write       = 1'b0;
        flush          = 1'b0;
        imem_req_valid = 1'b0;

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                imem_req_valid = !branch_taken;
                if (!branch_taken && imem_req_ready) begin
                    req_pc_d = pc_cur;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    state_d = imem_resp_valid ? REQ : DRAIN;
                end else if (imem_resp_valid) begin
                    if (!hazard_stall) begin
                        deliver   = 1'b1;
                        dlv_instr = imem_resp_data;
                        state_d   = REQ;
                    end else begin
                        buf_d   = imem_resp_data;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    state_d = REQ;
                end else if (!hazard_stall) begin
                    deliver = 1'b1;
                    state_d = REQ;
                end
            end
            DRAIN: begin
                // A response coinciding with a redirect is the one being drained.
                if (imem_resp_valid) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase

        if (redirect) begin
            pc_next  = branch_target & ALIGN;
            pc_write = 1'b1;
            flush    = 1'b1;
        end else if (deliver) begin
            pc_next  = req_pc_q + STEP;
            pc_write = 1'b1;
        end

        if (redirect)          if_valid_d = 1'b0;
        else if (deliver)      if_valid_d = 1'b1;
        else if (hazard_stall) if_valid_d = if_valid_q;
        else                   if_valid_d = 1'b0;
        if_pc_d    = deliver ? req_pc_q : if_pc_q;
        if_instr_d = deliver ? dlv_instr : if_instr_q;

        if (reset) begin
            pc_next        = '0;
            pc_write       = 1'b0;
            flush          = 1'b0;
            imem_req_valid = 1'b0;
        end
    end

    assign imem_req_addr = reset ? '0 : pc_cur;
    assign if_valid      = if_valid_q;
    assign if_pc         = if_pc_q;
    assign if_instr      = if_instr_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, hand-written corner sequences and
// randomized traffic checked against a transaction-level reference model.
module tb_fetch_ctrl;

    localparam logic        L = 1'b0;
    localparam logic        H = 1'b1;
    localparam logic [31:0] XK = 32'hA5A5_A5A5;
    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] pc_cur, pc_next, branch_target, imem_req_addr, if_pc;
    logic        pc_write, hazard_stall, branch_taken, imem_req_valid;
    logic        imem_req_ready, imem_resp_valid, if_valid, flush;
    logic [31:0] imem_resp_data, if_instr;

    always #5 clk = ~clk;

    fetch_ctrl #(.ADDR_W(64), .INSTR_W(32), .PC_STEP(4)) dut (
        .clk(clk), .reset(reset), .pc_cur(pc_cur), .pc_next(pc_next),
        .pc_write(pc_write), .hazard_stall(hazard_stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .if_valid(if_valid), .if_pc(if_pc),
        .if_instr(if_instr), .flush(flush)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one outstanding fetch, an optional parked instruction,
    // and a flag marking the outstanding fetch as already cancelled.
    logic        m_started, m_out, m_disc, m_hold, m_ifv;
    logic [63:0] m_out_pc, m_hold_pc, m_ifpc;
    logic [31:0] m_hold_i, m_ifi;
    logic        e_br, e_real, e_dlv, e_rv, e_pw, e_fl;
    logic [63:0] e_dpc, e_ra, e_pn;
    logic [31:0] e_di;

    logic        mem_pend;
    int          mem_cnt;
    logic [63:0] mem_addr;

    typedef struct {
        logic st, br, rdy, rv;
        logic [63:0] tgt;
        logic [31:0] rd;
        logic x_pw, x_rv, x_fl, x_ifv;
        logic [63:0] x_pn, x_ifpc;
        logic [31:0] x_ifi;
    } vec_t;
    vec_t tbl[18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic eval_model();
        e_real = m_out && imem_resp_valid;
        e_dpc  = m_hold ? m_hold_pc : m_out_pc;
        e_di   = m_hold ? m_hold_i : imem_resp_data;
        if (reset) begin
            e_br = 0; e_dlv = 0; e_rv = 0; e_ra = '0; e_pw = 0; e_pn = '0; e_fl = 0;
        end else begin
            e_br  = m_started && branch_taken;
            e_dlv = !e_br && !hazard_stall && (m_hold || (e_real && !m_disc));
            e_rv  = m_started && !m_out && !m_hold && !e_br;
            e_ra  = pc_cur;
            e_fl  = e_br;
            e_pw  = e_br || e_dlv;
            e_pn  = e_br ? {branch_target[63:2], 2'b00} : (e_dlv ? e_dpc + 64'd4 : pc_cur);
        end
    endtask

    task automatic check_model();
        chk("req_valid", imem_req_valid, e_rv);
        chk("req_addr", imem_req_addr, e_ra);
        chk("pc_write", pc_write, e_pw);
        chk("pc_next", pc_next, e_pn);
        chk("flush", flush, e_fl);
        chk("if_valid", if_valid, m_ifv);
        chk("if_pc", if_pc, m_ifpc);
        chk("if_instr", {32'h0, if_instr}, {32'h0, m_ifi});
    endtask

    task automatic drive(input logic rst, input logic st, input logic br, input logic [63:0] tgt,
                         input logic rdy, input logic rv, input logic [31:0] rd);
        reset = rst; hazard_stall = st; branch_taken = br; branch_target = tgt;
        imem_req_ready = rdy; imem_resp_valid = rv; imem_resp_data = rd;
        #1;
        eval_model();
        check_model();
    endtask

    task automatic advance();
        logic [63:0] npc;
        npc = e_pw ? e_pn : pc_cur;
        if (reset) begin
            m_started = 0; m_out = 0; m_disc = 0; m_hold = 0;
            m_ifv = 0; m_ifpc = '0; m_ifi = '0;
        end else begin
            if (e_br)              m_ifv = 0;
            else if (e_dlv)        begin m_ifv = 1; m_ifpc = e_dpc; m_ifi = e_di; end
            else if (!hazard_stall) m_ifv = 0;
            if (m_hold && (e_br || !hazard_stall)) m_hold = 0;
            if (e_real) begin
                m_out = 0;
                if (!m_disc && !e_br && hazard_stall) begin
                    m_hold = 1; m_hold_pc = m_out_pc; m_hold_i = imem_resp_data;
                end
            end else if (m_out && e_br) begin
                m_disc = 1;
            end
            if (e_rv && imem_req_ready) begin
                m_out = 1; m_out_pc = pc_cur; m_disc = 0;
            end
            m_started = 1;
        end
        @(posedge clk);
        @(negedge clk);
        pc_cur = npc;
    endtask

    initial begin
        m_started = 0; m_out = 0; m_disc = 0; m_hold = 0; m_ifv = 0;
        m_out_pc = '0; m_hold_pc = '0; m_ifpc = '0; m_hold_i = '0; m_ifi = '0;
        mem_pend = 0; mem_cnt = 0; mem_addr = '0;
        pc_cur = '0; reset = 1; hazard_stall = 0; branch_taken = 0; branch_target = '0;
        imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = '0;

        //          st br rdy rv  tgt          rd            pw rv fl ifv pc_next      if_pc        if_instr
        tbl[0]  = '{L, L, H, L, 64'h0,   32'h0,         L, L, L, L, 64'h0,   64'h0,   32'h0};
        tbl[1]  = '{L, L, H, L, 64'h0,   32'h0,         L, H, L, L, 64'h0,   64'h0,   32'h0};
        tbl[2]  = '{L, L, H, H, 64'h0,   32'hA5A5A5A5,  H, L, L, L, 64'h4,   64'h0,   32'h0};
        tbl[3]  = '{L, L, H, L, 64'h0,   32'h0,         L, H, L, H, 64'h4,   64'h0,   32'hA5A5A5A5};
        tbl[4]  = '{L, L, H, H, 64'h0,   32'hA5A5A5A1,  H, L, L, L, 64'h8,   64'h0,   32'h0};
        tbl[5]  = '{L, L, H, L, 64'h0,   32'h0,         L, H, L, H, 64'h8,   64'h4,   32'hA5A5A5A1};
        tbl[6]  = '{H, L, H, H, 64'h0,   32'hA5A5A5AD,  L, L, L, L, 64'h8,   64'h0,   32'h0};
        tbl[7]  = '{H, L, H, L, 64'h0,   32'h0,         L, L, L, L, 64'h8,   64'h0,   32'h0};
        tbl[8]  = '{H, L, H, L, 64'h0,   32'h0,         L, L, L, L, 64'h8,   64'h0,   32'h0};
        tbl[9]  = '{L, L, H, L, 64'h0,   32'h0,         H, L, L, L, 64'hC,   64'h0,   32'h0};
        tbl[10] = '{L, L, H, L, 64'h0,   32'h0,         L, H, L, H, 64'hC,   64'h8,   32'hA5A5A5AD};
        tbl[11] = '{L, H, H, L, 64'h103, 32'h0,         H, L, H, L, 64'h100, 64'h0,   32'h0};
        tbl[12] = '{L, L, H, H, 64'h0,   32'hDEADBEEF,  L, L, L, L, 64'h100, 64'h0,   32'h0};
        tbl[13] = '{L, L, H, L, 64'h0,   32'h0,         L, H, L, L, 64'h100, 64'h0,   32'h0};
        tbl[14] = '{L, H, H, H, 64'h200, 32'hA5A5A4A5,  H, L, H, L, 64'h200, 64'h0,   32'h0};
        tbl[15] = '{L, L, H, L, 64'h0,   32'h0,         L, H, L, L, 64'h200, 64'h0,   32'h0};
        tbl[16] = '{L, L, H, H, 64'h0,   32'hA5A5A7A5,  H, L, L, L, 64'h204, 64'h0,   32'h0};
        tbl[17] = '{L, L, L, L, 64'h0,   32'h0,         L, H, L, H, 64'h204, 64'h200, 32'hA5A5A7A5};

        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 1, 64'h55, 1, 1, 32'h1);
            advance();
        end

        for (int i = 0; i < 18; i++) begin
            drive(0, tbl[i].st, tbl[i].br, tbl[i].tgt, tbl[i].rdy, tbl[i].rv, tbl[i].rd);
            chk($sformatf("tbl%0d_pc_write", i), pc_write, tbl[i].x_pw);
            chk($sformatf("tbl%0d_pc_next", i), pc_next, tbl[i].x_pn);
            chk($sformatf("tbl%0d_req_valid", i), imem_req_valid, tbl[i].x_rv);
            chk($sformatf("tbl%0d_flush", i), flush, tbl[i].x_fl);
            chk($sformatf("tbl%0d_if_valid", i), if_valid, tbl[i].x_ifv);
            if (tbl[i].x_ifv) begin
                chk($sformatf("tbl%0d_if_pc", i), if_pc, tbl[i].x_ifpc);
                chk($sformatf("tbl%0d_if_instr", i), {32'h0, if_instr}, {32'h0, tbl[i].x_ifi});
            end
            advance();
        end

        // PC wrap at the top of the address space
        drive(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0);
        chk("wrap_redirect", pc_next, WRAP_PC);
        advance();
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("wrap_req_addr", imem_req_addr, WRAP_PC);
        advance();
        drive(0, 0, 0, 0, 0, 1, 32'h1234_5678);
        chk("wrap_pc_next", pc_next, 64'h0);
        chk("wrap_pc_write", pc_write, 1);
        advance();
        drive(0, 0, 1, 64'h340, 0, 0, 0);
        chk("wrap_if_pc", if_pc, WRAP_PC);
        advance();

        // Reset while waiting for a response
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("pre_rst_req_addr", imem_req_addr, 64'h340);
        advance();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("rst_wait_req_valid", imem_req_valid, 0);
        advance();
        drive(0, 0, 1, 64'h40, 0, 1, 32'hBAD0_0001);
        chk("rst_wait_if_pc", if_pc, 64'h0);
        chk("rst_wait_flush", flush, 0);
        chk("rst_wait_pc_write", pc_write, 0);
        advance();
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("restart_req_valid", imem_req_valid, 1);
        chk("restart_req_addr", imem_req_addr, 64'h340);
        advance();

        // Reset while parked in the hold buffer
        drive(0, 1, 0, 0, 0, 1, 32'h5555_AAAA);
        chk("hold_entry_pc_write", pc_write, 0);
        advance();
        drive(1, 1, 0, 0, 0, 0, 0);
        advance();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("rst_hold_pc_write", pc_write, 0);
        chk("rst_hold_if_valid", if_valid, 0);
        advance();
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("restart2_req_addr", imem_req_addr, 64'h340);
        advance();
        mem_pend = 1; mem_cnt = 0; mem_addr = 64'h340;

        for (int i = 0; i < 3000; i++) begin
            logic        r_rst, r_rv;
            logic [31:0] r_rd;
            r_rst = ($urandom_range(0, 199) == 0);
            r_rd  = $urandom;
            r_rv  = 0;
            if (mem_pend && mem_cnt == 0) begin
                r_rv = 1; r_rd = mem_addr[31:0] ^ XK;
            end else if (!mem_pend && !m_out && $urandom_range(0, 99) < 5) begin
                r_rv = 1;
            end
            drive(r_rst, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 8,
                  {$urandom, $urandom}, $urandom_range(0, 99) < 60, r_rv, r_rd);
            if (reset) begin
                mem_pend = 0;
            end else begin
                if (mem_pend) begin
                    if (mem_cnt == 0) mem_pend = 0;
                    else mem_cnt--;
                end
                if (e_rv && imem_req_ready) begin
                    mem_pend = 1; mem_cnt = $urandom_range(0, 2); mem_addr = pc_cur;
                end
            end
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
